// File: rtl/cdb_broadcaster_pkg.sv
// rtl/cdb_broadcaster_pkg.sv - shared defaults and helpers for the CDB broadcaster
// Contents:
//   CDB_N_SRC_DEF / CDB_DATA_W_DEF / CDB_ROB_ADDR_W_DEF : default bus geometry
//   rr_next(idx, n) : round-robin successor of a source index
package cdb_broadcaster_pkg;

    localparam int CDB_N_SRC_DEF      = 4;
    localparam int CDB_DATA_W_DEF     = 32;
    localparam int CDB_ROB_ADDR_W_DEF = 4;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/cdb_broadcaster_rr_arbiter.sv
// rtl/cdb_broadcaster_rr_arbiter.sv - combinational round-robin arbiter
// Ports:
//   req         : per-source request
//   ptr         : highest-priority index this cycle
//   grant       : one-hot grant (zero when no request)
//   grant_idx   : index of the granted source
//   grant_valid : some source was granted
module cdb_broadcaster_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] idx;

    // Walk ptr, ptr+1, ... wrapping at N; the first requester wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDX_W'((int'(ptr) + k) % N);
            if (!grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// rtl/cdb_broadcaster.sv - common data bus transmit end with round-robin arbitration
// Ports:
//   clk, rst (sync, active low), flush_en
//   src_*  : N_SRC writeback channels (valid/ready, rob addr, data, optional LO half)
//   bus_*  : registered main and lo broadcast channels, one cycle after transfer
// Optional: CDB_DUAL_BROADCAST_EN grants a second no-LO source per cycle and
//           broadcasts its main result on the lo channel.
module cdb_broadcaster
    import cdb_broadcaster_pkg::*;
#(
    parameter int N_SRC      = CDB_N_SRC_DEF,
    parameter int DATA_W     = CDB_DATA_W_DEF,
    parameter int ROB_ADDR_W = CDB_ROB_ADDR_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_en,
    input  logic [N_SRC-1:0]             src_valid,
    output logic [N_SRC-1:0]             src_ready,
    input  logic [N_SRC*ROB_ADDR_W-1:0]  src_rob_addr,
    input  logic [N_SRC*DATA_W-1:0]      src_data,
    input  logic [N_SRC-1:0]             src_has_lo,
    input  logic [N_SRC*ROB_ADDR_W-1:0]  src_lo_rob_addr,
    input  logic [N_SRC*DATA_W-1:0]      src_lo_data,
    output logic                         bus_en,
    output logic [DATA_W-1:0]            bus_ref_id,
    output logic [DATA_W-1:0]            bus_data,
    output logic                         bus_lo_en,
    output logic [DATA_W-1:0]            bus_lo_ref_id,
    output logic [DATA_W-1:0]            bus_lo_data
);

    localparam int IDX_W = $clog2(N_SRC);

    logic [ROB_ADDR_W-1:0] rob_a    [N_SRC];
    logic [DATA_W-1:0]     data_a   [N_SRC];
    logic [ROB_ADDR_W-1:0] lo_rob_a [N_SRC];
    logic [DATA_W-1:0]     lo_data_a[N_SRC];

    for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
        assign rob_a[i]     = src_rob_addr[i*ROB_ADDR_W +: ROB_ADDR_W];
        assign data_a[i]    = src_data[i*DATA_W +: DATA_W];
        assign lo_rob_a[i]  = src_lo_rob_addr[i*ROB_ADDR_W +: ROB_ADDR_W];
        assign lo_data_a[i] = src_lo_data[i*DATA_W +: DATA_W];
    end

    logic [IDX_W-1:0] ptr_q;
    logic [N_SRC-1:0] g1, g2;
    logic [IDX_W-1:0] w1, w2, w1_next, w2_next;
    logic             g1_valid, g2_valid;
    logic             allow, xfer;

    cdb_broadcaster_rr_arbiter #(.N(N_SRC), .IDX_W(IDX_W)) u_arb_main (
        .req         (src_valid),
        .ptr         (ptr_q),
        .grant       (g1),
        .grant_idx   (w1),
        .grant_valid (g1_valid)
    );

    assign w1_next = IDX_W'(rr_next(int'(w1), N_SRC));
    assign w2_next = IDX_W'(rr_next(int'(w2), N_SRC));

`ifdef CDB_DUAL_BROADCAST_EN
    logic [N_SRC-1:0] req2;

    // A first winner carrying a LO half already owns the lo channel.
    assign req2 = (g1_valid && !src_has_lo[w1]) ? (src_valid & ~g1 & ~src_has_lo) : '0;

    cdb_broadcaster_rr_arbiter #(.N(N_SRC), .IDX_W(IDX_W)) u_arb_dual (
        .req         (req2),
        .ptr         (w1_next),
        .grant       (g2),
        .grant_idx   (w2),
        .grant_valid (g2_valid)
    );
`else
    assign g2       = '0;
    assign w2       = '0;
    assign g2_valid = 1'b0;
`endif

    // Grants depend only on src_valid, flush_en and rst.
    assign allow     = rst && !flush_en;
    assign src_ready = allow ? (g1 | g2) : '0;
    assign xfer      = allow && g1_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q         <= '0;
            bus_en        <= 1'b0;
            bus_ref_id    <= '0;
            bus_data      <= '0;
            bus_lo_en     <= 1'b0;
            bus_lo_ref_id <= '0;
            bus_lo_data   <= '0;
        end else begin
            bus_en     <= xfer;
            bus_ref_id <= xfer ? DATA_W'(rob_a[w1]) : '0;
            bus_data   <= xfer ? data_a[w1] : '0;
            if (xfer && src_has_lo[w1]) begin
                bus_lo_en     <= 1'b1;
                bus_lo_ref_id <= DATA_W'(lo_rob_a[w1]);
                bus_lo_data   <= lo_data_a[w1];
            end else if (xfer && g2_valid) begin
                bus_lo_en     <= 1'b1;
                bus_lo_ref_id <= DATA_W'(rob_a[w2]);
                bus_lo_data   <= data_a[w2];
            end else begin
                bus_lo_en     <= 1'b0;
                bus_lo_ref_id <= '0;
                bus_lo_data   <= '0;
            end
            if (xfer) begin
                ptr_q <= g2_valid ? w2_next : w1_next;
            end
        end
    end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb/tb_cdb_broadcaster.sv - scoreboard bench for cdb_broadcaster
module tb_cdb_broadcaster;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush_en;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_ready;
    logic [N*AW-1:0] src_rob_addr;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]    src_has_lo;
    logic [N*AW-1:0] src_lo_rob_addr;
    logic [N*DW-1:0] src_lo_data;
    logic            bus_en;
    logic [DW-1:0]   bus_ref_id;
    logic [DW-1:0]   bus_data;
    logic            bus_lo_en;
    logic [DW-1:0]   bus_lo_ref_id;
    logic [DW-1:0]   bus_lo_data;

    always #5 clk = ~clk;

    cdb_broadcaster #(.N_SRC(N), .DATA_W(DW), .ROB_ADDR_W(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_en        (flush_en),
        .src_valid       (src_valid),
        .src_ready       (src_ready),
        .src_rob_addr    (src_rob_addr),
        .src_data        (src_data),
        .src_has_lo      (src_has_lo),
        .src_lo_rob_addr (src_lo_rob_addr),
        .src_lo_data     (src_lo_data),
        .bus_en          (bus_en),
        .bus_ref_id      (bus_ref_id),
        .bus_data        (bus_data),
        .bus_lo_en       (bus_lo_en),
        .bus_lo_ref_id   (bus_lo_ref_id),
        .bus_lo_data     (bus_lo_data)
    );

    typedef struct packed {
        logic          en;
        logic [DW-1:0] rid;
        logic [DW-1:0] data;
        logic          lo_en;
        logic [DW-1:0] lo_rid;
        logic [DW-1:0] lo_data;
    } bus_t;

    bus_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Source-side reference state: each producer holds its result until granted.
    bit            sv   [N];
    bit            slo  [N];
    logic [AW-1:0] srob [N];
    logic [AW-1:0] slrob[N];
    logic [DW-1:0] sdat [N];
    logic [DW-1:0] sldat[N];
    int            mptr;
    bit            m_rst;
    bit            m_flush;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int pick(input int from, input bit need_no_lo, input int skip);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (from + k) % N;
            if (sv[j] && j != skip && !(need_no_lo && slo[j])) return j;
        end
        return -1;
    endfunction

    task automatic load(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d,
                        input bit lo, input logic [AW-1:0] lr, input logic [DW-1:0] ld);
        sv[i] = 1'b1; srob[i] = r; sdat[i] = d; slo[i] = lo; slrob[i] = lr; sldat[i] = ld;
    endtask

    task automatic load_rand(input int i);
        load(i, AW'($urandom), $urandom, $urandom_range(1, 0) == 1, AW'($urandom), $urandom);
    endtask

    // One clock: drive, predict grants and next-cycle bus, check ready, advance model.
    task automatic step(input logic [N-1:0] want, input bit use_want);
        int   w1, w2;
        bus_t e;
        logic [N-1:0] er;
        for (int i = 0; i < N; i++) begin
            if (!sv[i]) begin
                srob[i] = AW'($urandom); sdat[i] = $urandom; slo[i] = $urandom_range(1, 0) == 1;
                slrob[i] = AW'($urandom); sldat[i] = $urandom;
            end
        end
        rst      = m_rst;
        flush_en = m_flush;
        for (int i = 0; i < N; i++) begin
            src_valid[i]                = sv[i];
            src_has_lo[i]               = slo[i];
            src_rob_addr[i*AW +: AW]    = srob[i];
            src_data[i*DW +: DW]        = sdat[i];
            src_lo_rob_addr[i*AW +: AW] = slrob[i];
            src_lo_data[i*DW +: DW]     = sldat[i];
        end
        #1;
        w1 = -1; w2 = -1; er = '0; e = '0;
        if (m_rst && !m_flush) begin
            w1 = pick(mptr, 1'b0, -1);
`ifdef CDB_DUAL_BROADCAST_EN
            if (w1 >= 0 && !slo[w1]) w2 = pick((w1 + 1) % N, 1'b1, w1);
`endif
        end
        if (w1 >= 0) begin
            er[w1] = 1'b1;
            e.en = 1'b1; e.rid = DW'(srob[w1]); e.data = sdat[w1];
            if (slo[w1]) begin
                e.lo_en = 1'b1; e.lo_rid = DW'(slrob[w1]); e.lo_data = sldat[w1];
            end else if (w2 >= 0) begin
                er[w2] = 1'b1;
                e.lo_en = 1'b1; e.lo_rid = DW'(srob[w2]); e.lo_data = sdat[w2];
            end
            sv[w1] = 1'b0;
            if (w2 >= 0) sv[w2] = 1'b0;
            mptr = ((w2 >= 0 ? w2 : w1) + 1) % N;
        end
        if (!m_rst) mptr = 0;
        chk("src_ready", src_ready, er);
        if (use_want) chk("plan_ready", src_ready, want);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) sv[i] = 1'b0;
    endtask

    // Monitor: compare each registered broadcast against the queued prediction.
    always @(posedge clk) begin
        bus_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("bus_en",        bus_en,        e.en);
            chk("bus_ref_id",    bus_ref_id,    e.rid);
            chk("bus_data",      bus_data,      e.data);
            chk("bus_lo_en",     bus_lo_en,     e.lo_en);
            chk("bus_lo_ref_id", bus_lo_ref_id, e.lo_rid);
            chk("bus_lo_data",   bus_lo_data,   e.lo_data);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; flush_en = 1'b0; src_valid = '0; src_has_lo = '0;
        src_rob_addr = '0; src_data = '0; src_lo_rob_addr = '0; src_lo_data = '0;
        m_rst = 1'b0; m_flush = 1'b0; mptr = 0;
        clear_all();
        @(negedge clk);

        // Reset with every source requesting.
        for (int i = 0; i < N; i++) load_rand(i);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        m_rst = 1'b1;
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b1000, 1'b1);
        step(4'b0000, 1'b1);

        // Single source.
        load(2, 4'h5, 32'hDEADBEEF, 1'b0, 4'h0, 32'h0);
        step(4'b0100, 1'b1);
        step(4'b0000, 1'b1);

        // Fairness with all sources continuously valid from ptr 0.
        m_rst = 1'b0; step(4'b0000, 1'b1); m_rst = 1'b1;
        for (int i = 0; i < N; i++) load_rand(i);
        for (int c = 0; c < 5; c++) begin
            step(4'b0001 << (c % N), 1'b1);
            for (int i = 0; i < N; i++) if (!sv[i]) load_rand(i);
        end

        // HI/LO pair.
        clear_all();
        m_rst = 1'b0; step(4'b0000, 1'b1); m_rst = 1'b1;
        load(1, 4'h3, 32'h1, 1'b1, 4'h4, 32'h2);
        step(4'b0010, 1'b1);
        step(4'b0000, 1'b1);

        // Flush holds off a pending source for one cycle.
        load(0, 4'h7, 32'h0BAD_F00D, 1'b0, 4'h0, 32'h0);
        m_flush = 1'b1;
        step(4'b0000, 1'b1);
        m_flush = 1'b0;
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);

`ifdef CDB_DUAL_BROADCAST_EN
        m_rst = 1'b0; step(4'b0000, 1'b1); m_rst = 1'b1;
        load(0, 4'h1, 32'hA0, 1'b0, 4'h0, 32'h0);
        load(2, 4'h2, 32'hA2, 1'b0, 4'h0, 32'h0);
        step(4'b0101, 1'b1);
        load(2, 4'h6, 32'hB2, 1'b0, 4'h0, 32'h0);
        load(3, 4'h9, 32'hB3, 1'b1, 4'hA, 32'hC3);
        step(4'b1000, 1'b1);
        clear_all();
        step(4'b0000, 1'b1);
`endif

        // Randomised traffic with occasional flush and reset.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) if (!sv[i] && $urandom_range(99, 0) < 45) load_rand(i);
            m_flush = $urandom_range(15, 0) == 0;
            m_rst   = $urandom_range(39, 0) != 0;
            step('0, 1'b0);
        end
        m_flush = 1'b0; m_rst = 1'b1;
        clear_all();
        step(4'b0000, 1'b1);
        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Transmit end of the common data bus (CDB).
- Collects finished results from N functional-unit writeback channels over valid/ready handshakes.
- Round-robin arbitration picks one result per cycle and drives the registered main and lo broadcast channels consumed by every reservation-station line and the ROB.
- Lo channel carries the LO half of HI/LO-producing ops (mult/div) alongside the winner's main result.

Parameters:
- N_SRC, 4, number of functional-unit writeback channels (2..8).
- DATA_W, 32, data and ref-id width; ref id is the ROB address zero-extended to DATA_W.
- ROB_ADDR_W, 4, ROB address width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-low reset
- flush_en  input  1  pipeline flush; kills pending broadcast, grants nothing this cycle
- src_valid  input  N_SRC  per-source result valid
- src_ready  output  N_SRC  per-source grant, combinational, one-hot or zero (two-hot with macro)
- src_rob_addr  input  N_SRC*ROB_ADDR_W  main-result ROB address, source i at slice i
- src_data  input  N_SRC*DATA_W  main result data
- src_has_lo  input  N_SRC  source also carries a LO result
- src_lo_rob_addr  input  N_SRC*ROB_ADDR_W  LO-result ROB address
- src_lo_data  input  N_SRC*DATA_W  LO result data
- bus_en  output  1  main channel valid
- bus_ref_id  output  DATA_W  {zeros, rob_addr}
- bus_data  output  DATA_W  main data
- bus_lo_en  output  1  lo channel valid
- bus_lo_ref_id  output  DATA_W  {zeros, lo rob_addr}
- bus_lo_data  output  DATA_W  lo data

Behaviour:
- Reset, rst low at posedge: rr pointer = 0; all bus_* outputs = 0.
- Handshake:
  - Transfer on src_valid[i] & src_ready[i].
  - Sources hold valid and payload stable until granted; no retraction.
  - src_ready may depend combinationally on src_valid, never on other inputs except flush_en and rst.
- Arbitration:
  - Scan i = ptr, ptr+1, ... mod N_SRC.
  - First valid source is the winner.
  - src_ready[winner] = 1.
  - On transfer, ptr <= (winner+1) mod N_SRC.
  - No valid source: ptr unchanged.
- Output stage, latency 1: cycle after transfer:
  - bus_en = 1.
  - bus_ref_id/bus_data from the winner.
  - If src_has_lo[winner]: bus_lo_en = 1 with the winner's lo fields; else bus_lo_en = 0 and lo data/ref = 0.
  - Outputs stay valid exactly one cycle; no transfer means all bus_* = 0 next cycle.
- Throughput: one source per cycle, back-to-back; every valid source is granted within N_SRC cycles (starvation-free).
- flush_en high:
  - src_ready = 0.
  - Next-cycle bus_en = bus_lo_en = 0.
  - ptr unchanged.
  - The broadcast already on the bus this cycle is not retracted.
- rst low overrides flush_en; src_ready = 0 while in reset.
- Payload of non-granted sources is ignored; X on those must not propagate.

Optional Feature:
- Macro CDB_DUAL_BROADCAST_EN.
- Defined:
  - If the first winner has src_has_lo = 0, a second winner is chosen: the next valid source in rr order after the first with src_has_lo = 0.
  - The second winner is granted the same cycle and its main result is broadcast on the lo channel: bus_lo_ref_id/bus_lo_data = its rob_addr/data, bus_lo_en = 1.
  - ptr <= (second+1) mod N_SRC.
  - A first winner with has_lo = 1 blocks dual issue.
- Undefined: at most one grant per cycle; lo channel used only for LO halves.

Decomposition:
- Shared package/header (cdb.v): CDB_DATA_W, CDB_REF_W, widths of src bundles, ref-id zero-extension macro; reuse the existing bus.v and rob.v width defines.
- Sub-module rr_arbiter (N inputs, ptr in, one-hot grant out, grant index out).
- With the macro, instantiate it twice, second with the first grant masked and has_lo sources excluded.

Test Plan:
- Reset: rst = 0 for 2 cycles with all src_valid = 1 -> src_ready = 0, all bus_* = 0; after release, first grant is src 0.
- Single source: src 2 valid, rob 5, data 0xDEADBEEF, has_lo = 0 -> src_ready = 0100 same cycle; next cycle bus_en = 1, bus_ref_id = 0x5, bus_data = 0xDEADBEEF, bus_lo_en = 0.
- Fairness: all 4 valid continuously -> grants 0,1,2,3,0 on consecutive cycles; bus_en high every cycle.
- HI/LO: src 1 rob 3 data 0x1 has_lo, lo rob 4 lo data 0x2 -> next cycle bus_ref_id = 3, bus_data = 1, bus_lo_en = 1, bus_lo_ref_id = 4, bus_lo_data = 2.
- Flush: src 0 valid with flush_en = 1 -> src_ready = 0, next-cycle bus_en = 0; src 0 granted the cycle after flush drops.
- Macro on: src 0 and src 2 valid, no lo, ptr = 0 -> src_ready = 0101; next cycle main = src 0, lo channel = src 2, ptr = 3.
